// File: rtl/ecc_dec_engine.sv
// Multi-cycle SECDED decoder for 8/16/32-bit codewords: folds the syndrome
// SLICE_WIDTH bits per cycle, then corrects single-bit and flags double-bit errors.
module ecc_dec_engine #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int AMBA_WORD          = 32,
  parameter int SLICE_WIDTH        = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0]                data_in,
  input  logic [AMBA_WORD-1:0]                         work_mod,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [MAX_INFO_WIDTH-1:0]                    data_out,
  output logic [1:0]                                   num_of_errors,
  output logic [MAX_CODEWORD_WIDTH-MAX_INFO_WIDTH-1:0] syndrome
);
  localparam int CW        = MAX_CODEWORD_WIDTH;
  localparam int P         = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
  localparam int BEATS_MAX = CW / SLICE_WIDTH;
  localparam int BW        = $clog2(BEATS_MAX + 1);
  localparam int IW        = $clog2(CW);
  localparam int CNTW      = $clog2(CW + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCUM   = 2'd1;
  localparam logic [1:0] S_CORRECT = 2'd2;
  localparam logic [1:0] S_OUT     = 2'd3;

  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  function automatic logic [CW-1:0] h_row(input logic [1:0] mode, input int r);
    logic [31:0] v;
    v = '0;
    case (mode)
      2'd0: case (r)
              0: v = 32'h0000_00B1;
              1: v = 32'h0000_00D2;
              2: v = 32'h0000_00E4;
              3: v = 32'h0000_00FF;
              default: v = '0;
            endcase
      2'd1: case (r)
              0: v = 32'h0000_AB61;
              1: v = 32'h0000_CDA2;
              2: v = 32'h0000_F1C4;
              3: v = 32'h0000_FE08;
              4: v = 32'h0000_FFFF;
              default: v = '0;
            endcase
      2'd2: case (r)
              0: v = 32'hAAAB_56C1;
              1: v = 32'hCCCD_9B42;
              2: v = 32'hF0F1_E384;
              3: v = 32'hFF01_FC08;
              4: v = 32'hFFFE_0010;
              5: v = 32'hFFFF_FFFF;
              default: v = '0;
            endcase
      default: v = '0;
    endcase
    return v[CW-1:0];
  endfunction

  function automatic int n_of(input logic [1:0] mode);
    case (mode)
      2'd0:    return 8;
      2'd1:    return 16;
      2'd2:    return 32;
      default: return 0;
    endcase
  endfunction

  function automatic int k_of(input logic [1:0] mode);
    case (mode)
      2'd0:    return 4;
      2'd1:    return 11;
      2'd2:    return 26;
      default: return 0;
    endcase
  endfunction

  function automatic logic [CW-1:0] mask_of(input logic [1:0] mode);
    logic [CW-1:0] m;
    for (int i = 0; i < CW; i++) m[i] = (i < n_of(mode));
    return m;
  endfunction

  logic [1:0]      state, mode_q, mode_in;
  logic [CW-1:0]   cw_q, flip, corrected, info_shift;
  logic [CW-1:0]   h_cur [P];
  logic [P-1:0]    syn_acc, syn_next, col;
  logic [BW-1:0]   beat, last_beat;
  logic [CNTW-1:0] match_cnt;
  logic [IW-1:0]   match_idx;
  int              n_cur, k_cur;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_OUT);

  // NOTE: every variable gets a value at the top of each always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    mode_in = MODE_ILLEGAL;
    if      (work_mod == AMBA_WORD'(0)) mode_in = 2'd0;
    else if (work_mod == AMBA_WORD'(1)) mode_in = 2'd1;
    else if (work_mod == AMBA_WORD'(2)) mode_in = 2'd2;
  end

  always_comb begin
    n_cur     = n_of(mode_q);
    k_cur     = k_of(mode_q);
    last_beat = BW'((n_cur + SLICE_WIDTH - 1) / SLICE_WIDTH - 1);
    for (int r = 0; r < P; r++) h_cur[r] = h_row(mode_q, r);
  end

  // One beat: fold the current slice of every H row into the running syndrome.
  always_comb begin
    syn_next = syn_acc;
    for (int r = 0; r < P; r++)
      syn_next[r] = syn_acc[r] ^ (^(h_cur[r][beat*SLICE_WIDTH +: SLICE_WIDTH] &
                                    cw_q[beat*SLICE_WIDTH +: SLICE_WIDTH]));
  end

  always_comb begin
    match_cnt = '0;
    match_idx = '0;
    col       = '0;
    for (int i = 0; i < CW; i++) begin
      for (int r = 0; r < P; r++) col[r] = h_cur[r][i];
      if (i < n_cur && col == syn_acc) begin
        match_cnt = match_cnt + 1'b1;
        match_idx = IW'(i);
      end
    end
  end

  always_comb begin
    flip = '0;
    if (match_cnt == CNTW'(1)) flip[match_idx] = 1'b1;
    corrected  = cw_q ^ flip;
    info_shift = corrected >> (n_cur - k_cur);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_q        <= '0;
      cw_q          <= '0;
      syn_acc       <= '0;
      beat          <= '0;
      data_out      <= '0;
      num_of_errors <= '0;
      syndrome      <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          mode_q  <= mode_in;
          cw_q    <= data_in & mask_of(mode_in);
          syn_acc <= '0;
          beat    <= '0;
          state   <= (mode_in == MODE_ILLEGAL) ? S_CORRECT : S_ACCUM;
        end
        S_ACCUM: begin
          syn_acc <= syn_next;
          if (beat == last_beat) state <= S_CORRECT;
          else                   beat  <= beat + 1'b1;
        end
        S_CORRECT: begin
          if (mode_q == MODE_ILLEGAL) begin
            data_out      <= '0;
            syndrome      <= '0;
            num_of_errors <= 2'd3;
          end else begin
            data_out <= info_shift[MAX_INFO_WIDTH-1:0];
            syndrome <= syn_acc;
            if (syn_acc == '0)                num_of_errors <= 2'd0;
            else if (match_cnt == CNTW'(1))   num_of_errors <= 2'd1;
            else                              num_of_errors <= 2'd2;
          end
          state <= S_OUT;
        end
        default: if (out_ready) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_dec_engine.sv
// Randomized self-checking bench for ecc_dec_engine against a whole-word
// SECDED reference model (syndromes, correction, latency, handshakes).
module tb_ecc_dec_engine;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] data_in, work_mod;
  logic [25:0] data_out;
  logic [1:0]  num_of_errors;
  logic [5:0]  syndrome;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] H [3][6] = '{
    '{32'hB1, 32'hD2, 32'hE4, 32'hFF, 32'h0, 32'h0},
    '{32'hAB61, 32'hCDA2, 32'hF1C4, 32'hFE08, 32'hFFFF, 32'h0},
    '{32'hAAAB56C1, 32'hCCCD9B42, 32'hF0F1E384, 32'hFF01FC08, 32'hFFFE0010, 32'hFFFFFFFF}
  };

  ecc_dec_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .work_mod(work_mod), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out),
    .num_of_errors(num_of_errors), .syndrome(syndrome)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int n_of(input int m);
    return (m == 0) ? 8 : (m == 1) ? 16 : 32;
  endfunction

  function automatic int k_of(input int m);
    return (m == 0) ? 4 : (m == 1) ? 11 : 26;
  endfunction

  function automatic logic [31:0] mask_n(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [5:0] syn_of(input logic [31:0] cw, input int m);
    logic [5:0] s;
    for (int r = 0; r < 6; r++) s[r] = ^(H[m][r] & cw);
    return s;
  endfunction

  // Expected decode of one transaction, computed over the whole codeword at once.
  task automatic model(input logic [31:0] din, input logic [31:0] wm,
                       output logic [25:0] d, output logic [1:0] e,
                       output logic [5:0] s, output int lat);
    int m, n, k, hits, pos;
    logic [31:0] cw, row;
    logic [5:0]  col;
    if (wm > 32'd2) begin
      d = '0; e = 2'd3; s = '0; lat = 2;
    end else begin
      m  = int'(wm);
      n  = n_of(m);
      k  = k_of(m);
      cw = din & mask_n(n);
      s  = syn_of(cw, m);
      hits = 0;
      pos  = 0;
      for (int i = 0; i < n; i++) begin
        for (int r = 0; r < 6; r++) begin
          row    = H[m][r];
          col[r] = row[i];
        end
        if (s != 6'd0 && col == s) begin
          hits++;
          pos = i;
        end
      end
      if (s == 6'd0)     e = 2'd0;
      else if (hits == 1) begin
        e = 2'd1;
        cw[pos] = ~cw[pos];
      end else           e = 2'd2;
      d   = 26'((cw >> (n - k)) & mask_n(k));
      lat = (n + 7) / 8 + 2;
    end
  endtask

  // Brute-force the parity bits that make a clean codeword for the given info bits.
  function automatic logic [31:0] encode(input int m, input logic [31:0] info_raw);
    int n, k;
    logic [31:0] base, cw;
    n    = n_of(m);
    k    = k_of(m);
    base = (info_raw & mask_n(k)) << (n - k);
    for (int p = 0; p < (1 << (n - k)); p++) begin
      cw = base | 32'(p);
      if (syn_of(cw, m) == 6'd0) return cw;
    end
    return base;
  endfunction

  // Called on a negedge with the engine idle; ends on a negedge after the out handshake.
  task automatic run_txn(input logic [31:0] din, input logic [31:0] wm, input int hold, input string tag);
    logic [25:0] ed;
    logic [1:0]  ee;
    logic [5:0]  es;
    int          el, lat;
    model(din, wm, ed, ee, es, el);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    data_in  = din;
    work_mod = wm;
    out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && lat < 40) begin
      data_in  = $urandom;
      work_mod = $urandom_range(0, 3);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, ".latency"}, 32'(lat), 32'(el));
    if (out_valid) begin
      check({tag, ".data_out"}, 32'(data_out), 32'(ed));
      check({tag, ".num_err"}, 32'(num_of_errors), 32'(ee));
      check({tag, ".syndrome"}, 32'(syndrome), 32'(es));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".hold_data"}, 32'({data_out, num_of_errors, syndrome}), 32'({ed, ee, es}));
        check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".drop_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".ready_again"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cw, din, wm;
    int m, n, nflip, b0, b1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; work_mod = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.outputs", 32'({data_out, num_of_errors, syndrome}), 32'd0);
    rst = 1'b0;
    #1;
    check("rst.release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    run_txn(32'h0000_00FF, 32'd0, 0, "m0_clean");
    run_txn(32'h0000_00FE, 32'd0, 0, "m0_single");
    run_txn(32'h0000_0030, 32'd0, 0, "m0_double");
    run_txn(32'h8000_0000, 32'd2, 0, "m2_bit31");
    run_txn(32'h1234_5678, 32'd3, 0, "illegal");
    run_txn(32'hABCD_00FE, 32'd0, 10, "backpressure");

    // Abort a mode 2 codeword mid-accumulation.
    in_valid = 1'b1; data_in = 32'h8000_0000; work_mod = 32'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd0);
    check("abort.outputs", 32'({data_out, num_of_errors, syndrome}), 32'd0);
    rst = 1'b0;
    b0 = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) b0++;
    end
    check("abort.no_output", 32'(b0), 32'd0);
    run_txn(32'h8000_0000, 32'd2, 0, "after_abort");

    for (int t = 0; t < 50; t++) begin
      m = int'($urandom_range(0, 3));
      if (m == 3) begin
        wm  = 32'd3 + $urandom_range(0, 1000);
        din = $urandom;
      end else begin
        wm    = 32'(m);
        n     = n_of(m);
        cw    = encode(m, $urandom);
        nflip = int'($urandom_range(0, 2));
        b0    = int'($urandom_range(0, n - 1));
        b1    = (b0 + 1 + int'($urandom_range(0, n - 2))) % n;
        if (nflip >= 1) cw[b0] = ~cw[b0];
        if (nflip == 2) cw[b1] = ~cw[b1];
        din = (n < 32) ? (cw | ($urandom << n)) : cw;
      end
      run_txn(din, wm, int'($urandom_range(0, 3)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
